// File: rtl/sd_dma_copier_if.sv
// SD buffer and memory bus bundle for the SD DMA copier.
// master = DMA engine side, slave = buffer RAM / memory fabric side.
interface sd_dma_copier_if #(
    parameter int BUF_AW = 10
);
    logic              bufEn;
    logic [3:0]        bufWe;
    logic [BUF_AW-1:0] bufAddr;
    logic [31:0]       bufDin;
    logic [31:0]       bufDout;
    logic              memReq;
    logic [3:0]        memWe;
    logic [31:0]       memAddr;
    logic [31:0]       memDout;
    logic [31:0]       memDin;
    logic              memAck;

    modport master (
        output bufEn, bufWe, bufAddr, bufDin,
        input  bufDout,
        output memReq, memWe, memAddr, memDout,
        input  memDin, memAck
    );

    modport slave (
        input  bufEn, bufWe, bufAddr, bufDin,
        output bufDout,
        input  memReq, memWe, memAddr, memDout,
        output memDin, memAck
    );
endinterface

// File: rtl/sd_dma_copier.sv
// Word-at-a-time DMA between the SD data buffer and system memory.
// Define SD_DMA_BYTESWAP_EN to byte-reverse every word in flight.
module sd_dma_copier #(
    parameter int BUF_AW = 10
) (
    input  logic                clkCPU,
    input  logic                globlRst,
    input  logic                start,
    input  logic                dir,
    input  logic [31:0]         cfgMemAddr,
    input  logic [BUF_AW-1:0]   cfgBufAddr,
    input  logic [BUF_AW:0]     cfgCount,
    input  logic                abort,
    input  logic                irqClr,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                irq,
    sd_dma_copier_if.master     bus
);
    typedef enum logic [2:0] {
        IDLE, BUF_RD, BUF_WAIT, MEM_WR, MEM_RD, BUF_WR, FINISH
    } state_t;

    localparam logic [BUF_AW-1:0] BADDR_ONE = {{(BUF_AW-1){1'b0}}, 1'b1};
    localparam logic [BUF_AW:0]   REM_ONE   = {{BUF_AW{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              dir_q, dir_d;
    logic              abort_q, abort_d;
    logic [BUF_AW-1:0] baddr_q, baddr_d;
    logic [29:0]       maddr_q, maddr_d;
    logic [BUF_AW:0]   rem_q, rem_d;
    logic [31:0]       data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              irq_q, irq_d;
    logic              buf_en_q, buf_en_d;
    logic [3:0]        buf_we_q, buf_we_d;
    logic              mem_req_q, mem_req_d;
    logic [3:0]        mem_we_q, mem_we_d;
    logic              word_done;
    logic              unused_mem_lsb;

    assign unused_mem_lsb = ^cfgMemAddr[1:0];

    function automatic logic [31:0] xfer(input logic [31:0] w);
`ifdef SD_DMA_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        abort_d   = abort_q;
        baddr_d   = baddr_q;
        maddr_d   = maddr_q;
        rem_d     = rem_q;
        data_d    = data_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        word_done = 1'b0;
        if (state_q != IDLE) begin
            abort_d = abort_q | abort;
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d   = dir;
                    maddr_d = cfgMemAddr[31:2];
                    baddr_d = cfgBufAddr;
                    rem_d   = cfgCount;
                    abort_d = 1'b0;
                    if (cfgCount == '0) begin
                        state_d = FINISH;
                    end else if (dir) begin
                        state_d = MEM_RD;
                    end else begin
                        state_d = BUF_RD;
                    end
                end
            end
            BUF_RD:   state_d = BUF_WAIT;
            BUF_WAIT: begin
                data_d  = xfer(bus.bufDout);
                state_d = MEM_WR;
            end
            MEM_WR:   word_done = bus.memAck;
            MEM_RD: begin
                if (bus.memAck) begin
                    data_d  = xfer(bus.memDin);
                    state_d = BUF_WR;
                end
            end
            BUF_WR:   word_done = 1'b1;
            FINISH: begin
                done_d    = ~abort_q;
                aborted_d = abort_q;
                state_d   = IDLE;
            end
            default:  state_d = IDLE;
        endcase
        // a pending abort is honoured only once the current word is complete
        if (word_done) begin
            baddr_d = baddr_q + BADDR_ONE;
            maddr_d = maddr_q + 30'd1;
            rem_d   = rem_q - REM_ONE;
            if (rem_q == REM_ONE || abort_d) begin
                state_d = FINISH;
            end else begin
                state_d = dir_q ? MEM_RD : BUF_RD;
            end
        end
        if (state_q == FINISH) begin
            irq_d = 1'b1;
        end else if (irqClr || (state_q == IDLE && start)) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
        busy_d    = state_d != IDLE;
        buf_en_d  = state_d == BUF_RD || state_d == BUF_WR;
        buf_we_d  = (state_d == BUF_WR) ? 4'hF : 4'h0;
        mem_req_d = state_d == MEM_WR || state_d == MEM_RD;
        mem_we_d  = (state_d == MEM_WR) ? 4'hF : 4'h0;
    end

    always_ff @(posedge clkCPU or negedge globlRst) begin
        if (!globlRst) begin
            state_q   <= IDLE;
            dir_q     <= 1'b0;
            abort_q   <= 1'b0;
            baddr_q   <= '0;
            maddr_q   <= '0;
            rem_q     <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            irq_q     <= 1'b0;
            buf_en_q  <= 1'b0;
            buf_we_q  <= 4'h0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 4'h0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            abort_q   <= abort_d;
            baddr_q   <= baddr_d;
            maddr_q   <= maddr_d;
            rem_q     <= rem_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            irq_q     <= irq_d;
            buf_en_q  <= buf_en_d;
            buf_we_q  <= buf_we_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign irq         = irq_q;
    assign bus.bufEn   = buf_en_q;
    assign bus.bufWe   = buf_we_q;
    assign bus.bufAddr = baddr_q;
    assign bus.bufDin  = data_q;
    assign bus.memReq  = mem_req_q;
    assign bus.memWe   = mem_we_q;
    assign bus.memAddr = {maddr_q, 2'b00};
    assign bus.memDout = data_q;
endmodule

// File: tb/tb_sd_dma_copier.sv
// Bench for sd_dma_copier: bus responders, transaction scoreboard,
// per-cycle handshake checks and directed jobs.
module tb_sd_dma_copier;
    localparam int AW = 10;

    logic          clkCPU = 1'b0;
    logic          globlRst = 1'b0;
    logic          start = 1'b0;
    logic          dir = 1'b0;
    logic [31:0]   cfgMemAddr = '0;
    logic [AW-1:0] cfgBufAddr = '0;
    logic [AW:0]   cfgCount = '0;
    logic          abort = 1'b0;
    logic          irqClr = 1'b0;
    logic          busy, done, aborted, irq;

    sd_dma_copier_if #(.BUF_AW(AW)) bus ();

    sd_dma_copier #(.BUF_AW(AW)) dut (
        .clkCPU     (clkCPU),
        .globlRst   (globlRst),
        .start      (start),
        .dir        (dir),
        .cfgMemAddr (cfgMemAddr),
        .cfgBufAddr (cfgBufAddr),
        .cfgCount   (cfgCount),
        .abort      (abort),
        .irqClr     (irqClr),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .irq        (irq),
        .bus        (bus)
    );

    always #5 clkCPU = ~clkCPU;

    int tests = 0;
    int fails = 0;

    logic [31:0] bufmem [1024];
    logic [63:0] exp_mem[$];
    logic [63:0] exp_buf[$];
    logic [31:0] rdq[$];
    logic [31:0] mlog_a[$];
    logic [31:0] mlog_d[$];
    logic [31:0] blog_a[$];
    int ack_delay = 2;
    int ack_cnt = 0;
    int done_n = 0;
    int abort_n = 0;
    int act_n = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef SD_DMA_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // reference model: the words a job of n completed words must produce
    task automatic expect_job(input logic d, input logic [31:0] ma,
                              input logic [AW-1:0] ba, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0]   a;
            logic [AW-1:0] b;
            a = {ma[31:2], 2'b00} + 32'(4 * i);
            b = ba + AW'(i);
            if (!d) exp_mem.push_back({a, sw(bufmem[b])});
            else    exp_buf.push_back({32'(b), sw(rdq[i])});
        end
    endtask

    // memory and buffer responders, driven 2 time units after the edge
    always @(posedge clkCPU) begin
        #2;
        if (!globlRst) begin
            bus.memAck = 1'b0;
            ack_cnt = 0;
        end else begin
            if (bus.memAck) begin
                bus.memAck = 1'b0;
                ack_cnt = 0;
            end else if (bus.memReq) begin
                ack_cnt++;
                if (ack_cnt > ack_delay) begin
                    bus.memAck = 1'b1;
                    if (!bus.memWe[0]) begin
                        bus.memDin = (rdq.size() > 0) ? rdq.pop_front() : 32'h0;
                    end
                end
            end
            if (bus.bufEn && bus.bufWe == 4'h0) bus.bufDout = bufmem[bus.bufAddr];
        end
    end

    logic        pv_req = 1'b0;
    logic        pv_ack = 1'b0;
    logic [3:0]  pv_we;
    logic [31:0] pv_addr, pv_dout;

    always @(negedge clkCPU) begin
        if (globlRst) begin
            if (bus.memReq || bus.bufEn) begin
                act_n++;
                chk("busy_during_bus", busy, 1);
            end
            if (done)    done_n++;
            if (aborted) abort_n++;
            if (done || aborted) chk("irq_at_finish", irq, 1);
            if (pv_req && !pv_ack) begin
                chk("req_hold", {bus.memReq, bus.memWe, bus.memAddr},
                    {1'b1, pv_we, pv_addr});
                if (pv_we == 4'hF) chk("dout_hold", bus.memDout, pv_dout);
            end
            if (bus.memReq && bus.memAck && bus.memWe == 4'hF) begin
                if (exp_mem.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL mem_wr: unexpected write %0h", bus.memAddr);
                end else begin
                    chk("mem_wr", {bus.memAddr, bus.memDout}, exp_mem.pop_front());
                end
                mlog_a.push_back(bus.memAddr);
                mlog_d.push_back(bus.memDout);
            end
            if (bus.bufEn && bus.bufWe == 4'hF) begin
                if (exp_buf.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL buf_wr: unexpected write %0h", bus.bufAddr);
                end else begin
                    chk("buf_wr", {32'(bus.bufAddr), bus.bufDin}, exp_buf.pop_front());
                end
                bufmem[bus.bufAddr] = bus.bufDin;
                blog_a.push_back(32'(bus.bufAddr));
            end
            pv_req  = bus.memReq;
            pv_ack  = bus.memAck;
            pv_we   = bus.memWe;
            pv_addr = bus.memAddr;
            pv_dout = bus.memDout;
        end else begin
            pv_req = 1'b0;
        end
    end

    task automatic go(input logic d, input logic [31:0] ma,
                      input logic [AW-1:0] ba, input logic [AW:0] n);
        @(negedge clkCPU); #1;
        dir = d; cfgMemAddr = ma; cfgBufAddr = ba; cfgCount = n;
        start = 1'b1;
        @(negedge clkCPU); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string nm);
        int k;
        k = 0;
        while (!(done || aborted) && k < 300) begin
            @(negedge clkCPU);
            k++;
        end
        if (k >= 300) chk({nm, "_timeout"}, 1, 0);
    endtask

    task automatic wait_req(input string nm);
        int k;
        k = 0;
        while (!bus.memReq && k < 50) begin
            @(negedge clkCPU);
            k++;
        end
        if (k >= 50) chk({nm, "_req_timeout"}, 1, 0);
    endtask

    int d0, a0, c0;
    logic [31:0] lit;

    initial begin
        bus.memAck = 1'b0;
        bus.memDin = '0;
        bus.bufDout = '0;
        for (int i = 0; i < 1024; i++) bufmem[i] = 32'h0;
        bufmem[0] = 32'h11223344; bufmem[1] = 32'h55667788;
        bufmem[2] = 32'h99AABBCC; bufmem[3] = 32'hDDEEFF00;
        repeat (3) @(negedge clkCPU);
        chk("rst_status", {busy, done, aborted, irq}, 4'h0);
        chk("rst_bus", {bus.memReq, bus.memWe, bus.bufEn, bus.bufWe}, 10'h0);
        #1 globlRst = 1'b1;

        // SD buffer -> memory, 4 words
        ack_delay = 2; d0 = done_n;
        expect_job(1'b0, 32'h1000, '0, 4);
        go(1'b0, 32'h1000, '0, 11'd4);
        wait_end("b2m");
        chk("b2m_done", {done, aborted}, 2'b10);
        chk("b2m_irq", irq, 1);
        @(negedge clkCPU);
        chk("b2m_left", exp_mem.size(), 0);
        chk("b2m_nwr", mlog_a.size(), 4);
        chk("b2m_addr0", mlog_a[0], 32'h1000);
        chk("b2m_addr3", mlog_a[3], 32'h100C);
`ifdef SD_DMA_BYTESWAP_EN
        lit = 32'h44332211;
`else
        lit = 32'h11223344;
`endif
        chk("b2m_data0", mlog_d[0], lit);
        chk("b2m_ndone", done_n - d0, 1);

        // memory -> SD buffer, 2 words; a start while busy is ignored
        rdq = '{32'hDEADBEEF, 32'hCAFEF00D};
        expect_job(1'b1, 32'h2000, 10'd16, 2);
        blog_a.delete();
        go(1'b1, 32'h2000, 10'd16, 11'd2);
        @(negedge clkCPU); #1;
        dir = 1'b0; cfgCount = '0; start = 1'b1;
        @(negedge clkCPU); #1;
        start = 1'b0;
        wait_end("m2b");
        chk("m2b_done", {done, aborted}, 2'b10);
        @(negedge clkCPU);
        chk("m2b_left", exp_buf.size(), 0);
        chk("m2b_addr", {blog_a[0], blog_a[1]}, {32'd16, 32'd17});
`ifdef SD_DMA_BYTESWAP_EN
        lit = 32'hEFBEADDE;
`else
        lit = 32'hDEADBEEF;
`endif
        chk("m2b_word0", bufmem[16], lit);

        // count 0, irqClr held: start clears irq, FINISH sets it anyway
        c0 = act_n;
        @(negedge clkCPU); #1;
        cfgCount = '0; start = 1'b1; irqClr = 1'b1;
        @(negedge clkCPU);
        chk("z_cyc1", {busy, done, irq}, 3'b100);
        #1 start = 1'b0;
        @(negedge clkCPU);
        chk("z_cyc2", {done, irq}, 2'b11);
        @(negedge clkCPU);
        chk("z_irqclr", irq, 0);
        #1 irqClr = 1'b0;
        chk("z_noact", act_n - c0, 0);

        // buffer address wrap 1023 -> 0 -> 1
        rdq = '{32'h01010101, 32'h02020202, 32'h03030303};
        expect_job(1'b1, 32'h4000, 10'd1023, 3);
        blog_a.delete();
        go(1'b1, 32'h4000, 10'd1023, 11'd3);
        wait_end("wrap");
        @(negedge clkCPU);
        chk("wrap_addr", {blog_a[0], blog_a[1], blog_a[2]},
            {32'd1023, 32'd0, 32'd1});
        chk("wrap_left", exp_buf.size(), 0);

        // abort while memAck withheld
        ack_delay = 5; d0 = done_n; a0 = abort_n;
        expect_job(1'b0, 32'h5000, '0, 1);
        go(1'b0, 32'h5000, '0, 11'd4);
        wait_req("abt");
        #1 abort = 1'b1;
        @(negedge clkCPU); #1;
        abort = 1'b0;
        chk("abt_req_held", bus.memReq, 1);
        wait_end("abt");
        chk("abt_pulse", {done, aborted}, 2'b01);
        c0 = act_n;
        repeat (10) @(negedge clkCPU);
        chk("abt_counts", {32'(done_n - d0), 32'(abort_n - a0)}, {32'd0, 32'd1});
        chk("abt_noact", act_n - c0, 0);
        chk("abt_left", exp_mem.size(), 0);

        // reset in the middle of MEM_WR, then a clean job
        d0 = done_n;
        go(1'b0, 32'h6000, '0, 11'd4);
        wait_req("rst");
        #1 globlRst = 1'b0;
        #1;
        chk("rst_mid", {bus.memReq, busy, irq}, 3'b000);
        exp_mem.delete();
        repeat (2) @(negedge clkCPU);
        #1 globlRst = 1'b1;
        repeat (2) @(negedge clkCPU);
        chk("rst_nodone", done_n - d0, 0);
        ack_delay = 0;
        bufmem[2] = 32'hA1B2C3D4;
        expect_job(1'b0, 32'h7003, 10'd2, 2);
        go(1'b0, 32'h7003, 10'd2, 11'd2);
        wait_end("post");
        chk("post_done", {done, aborted}, 2'b10);
        @(negedge clkCPU);
        chk("post_left", exp_mem.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sd_dma_copier.md
SD_DMA_COPIER -- requirements
Module: sd_dma_copier

Interface
REQ-001 SHALL have parameter BUF_AW, default 10, SD buffer word-address width (1024 words).
REQ-002 SHALL have port clkCPU  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port globlRst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle pulse, latches job config and begins a transfer.
REQ-005 SHALL have port dir  input  1  0 = SD buffer to memory, 1 = memory to SD buffer.
REQ-006 SHALL have port cfgMemAddr  input  32  memory byte address; bits [1:0] ignored.
REQ-007 SHALL have port cfgBufAddr  input  BUF_AW  starting buffer word address.
REQ-008 SHALL have port cfgCount  input  BUF_AW+1  word count, 0..1024.
REQ-009 SHALL have port abort  input  1  request early stop.
REQ-010 SHALL have port irqClr  input  1  clears irq.
REQ-011 SHALL have port busy, done, aborted, irq  output  1 each  status; done and aborted are one-cycle pulses, irq is a level.
REQ-012 SHALL have buffer port bufEn (out 1), bufWe (out 4), bufAddr (out BUF_AW), bufDin (out 32), bufDout (in 32); read data valid one cycle after bufEn with bufWe=0.
REQ-013 SHALL have memory port memReq (out 1), memWe (out 4), memAddr (out 32), memDout (out 32), memDin (in 32), memAck (in 1).

Function
REQ-014 SHALL implement states IDLE, BUF_RD, BUF_WAIT, MEM_WR, MEM_RD, BUF_WR, FINISH.
REQ-015 SHALL, in IDLE on start, latch all cfg inputs; count 0 -> FINISH directly with no bus activity; else dir=0 -> BUF_RD, dir=1 -> MEM_RD.
REQ-016 SHALL ignore start while busy.
REQ-017 SHALL, in BUF_RD, drive bufEn=1, bufWe=0 for exactly one cycle, then go to BUF_WAIT, capture bufDout into a data register, and go to MEM_WR.
REQ-018 SHALL, in MEM_WR, hold memReq=1, memWe=4'hF, memAddr, and memDout stable until the cycle memAck=1.
REQ-019 SHALL, in MEM_RD, hold memReq=1, memWe=0 until memAck=1, capturing memDin on that cycle, then go to BUF_WR.
REQ-020 SHALL, in BUF_WR, drive bufEn=1, bufWe=4'hF for one cycle.
REQ-021 SHALL, after each completed word, increment the buffer address modulo 2^BUF_AW (1023 wraps to 0), increment the memory address by 4 modulo 2^32, and decrement the remaining count; remaining 0 -> FINISH, else next word.
REQ-022 SHALL ignore memAck outside MEM_WR/MEM_RD.
REQ-023 SHALL record abort in a sticky flag; the flag takes effect only at a word boundary (never drops memReq before memAck) and routes to FINISH.
REQ-024 SHALL, in FINISH, pulse done (normal) or aborted (abort flag set) for one cycle, set irq, and return to IDLE.
REQ-025 SHALL drive busy=1 in every state except IDLE.
REQ-026 SHALL clear irq on irqClr or on an accepted start; if the FINISH set and irqClr coincide, set wins.
REQ-027 SHALL drive bufEn, bufWe, memReq, and memWe to 0 in all states not named above.

Reset
REQ-028 SHALL, on globlRst low, asynchronously force IDLE, clear the abort flag and counters, and drive all outputs to 0.
REQ-029 SHALL, on reset mid-transfer, drop memReq immediately with no completion pulse.

Configuration
REQ-030 SHALL, when SD_DMA_BYTESWAP_EN is defined, byte-reverse each word in flight ({b0,b1,b2,b3}), converting the SD big-endian buffer to CPU little-endian order and back.
REQ-031 SHALL, when SD_DMA_BYTESWAP_EN is undefined, pass data unchanged, with all cycle timing identical either way.

Verification
REQ-032 SHALL test dir=0, count=4, bufAddr=0, buffer words 0x11223344..., memAck after 2 cycles -> 4 memory writes at 0x1000, 0x1004, 0x1008, 0x100C, then a done pulse and irq=1; data is 0x44332211 with the macro and 0x11223344 without.
REQ-033 SHALL test dir=1, count=2, memDin=0xDEADBEEF/0xCAFEF00D -> two buffer writes at consecutive addresses, then done.
REQ-034 SHALL test count=0 -> done 2 cycles after start, with no bufEn or memReq.
REQ-035 SHALL test bufAddr=1023, count=3 -> buffer addresses 1023, 0, 1.
REQ-036 SHALL test abort asserted while memReq is held and memAck is withheld 5 cycles -> memReq stays high until ack, then an aborted pulse, no done pulse, and no further word.
REQ-037 SHALL test globlRst low mid-MEM_WR -> memReq=0 and busy=0 in the same cycle; a subsequent start works normally.
